// File: rtl/bloom_filter.sv
// Flow-membership Bloom filter: hashes a 104-bit 5-tuple key into a 2**ADDR_W bit array,
// one hash per cycle, reports hit/miss and optionally learns the key on a miss.
module bloom_filter #(
    parameter int ADDR_W   = 8,
    parameter int NUM_HASH = 3,
    parameter int LEARN    = 1,
    parameter logic [(2**ADDR_W)-1:0] INIT_VEC = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] ip_pro,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    output logic        readyRecv,
    output logic        readyRes,
    output logic        get_Result
);

    localparam int M      = 2**ADDR_W;
    localparam int KEY_W  = 104;
    localparam int NCHUNK = (KEY_W + ADDR_W - 1) / ADDR_W;
    localparam int PAD_W  = NCHUNK * ADDR_W;
    localparam int CNT_W  = $clog2(NUM_HASH + 1);

    localparam logic [7:0] SEEDS [0:7] = '{8'h00, 8'h5A, 8'hC3, 8'h96,
                                          8'h3C, 8'hA5, 8'h69, 8'hF0};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HASH   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t              r_state;
    logic [M-1:0]        r_array;
    logic [KEY_W-1:0]    r_key;
    logic                r_hit;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_idx [NUM_HASH];
    logic                r_ready_recv;
    logic                r_ready_res;
    logic                r_result;

    logic [KEY_W-1:0]    w_key;
    logic [ADDR_W-1:0]   w_hash [NUM_HASH];
    logic [ADDR_W-1:0]   w_cur_hash;
    logic                w_hit_next;
    logic                w_last;

    assign w_key = {ip_pro, src_port, dest_port};

    // Every hash is a fixed rotation of the latched key, so all of them are built
    // in parallel from wiring and the counter just selects which one is probed.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_HASH; gi++) begin : g_hash
            localparam int         ROT    = (11 * gi) % KEY_W;
            localparam logic [7:0] SEED_I = SEEDS[gi];

            logic [2*KEY_W-1:0] w_dbl;
            logic [KEY_W-1:0]   w_rot;
            logic [PAD_W-1:0]   w_pad;
            logic [ADDR_W-1:0]  w_fold;

            assign w_dbl = {r_key, r_key} << ROT;
            assign w_rot = w_dbl[2*KEY_W-1:KEY_W];
            assign w_pad = PAD_W'(w_rot);

            always_comb begin
                w_fold = '0;
                for (int c = 0; c < NCHUNK; c++) begin
                    w_fold = w_fold ^ w_pad[c*ADDR_W +: ADDR_W];
                end
            end

            assign w_hash[gi] = w_fold ^ ADDR_W'(SEED_I);
        end
    endgenerate

    always_comb begin
        w_cur_hash = w_hash[0];
        for (int i = 0; i < NUM_HASH; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_cur_hash = w_hash[i];
            end
        end
    end

    assign w_hit_next = r_hit & r_array[w_cur_hash];
    assign w_last     = (r_cnt == CNT_W'(NUM_HASH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_array      <= INIT_VEC;
            r_key        <= '0;
            r_hit        <= 1'b1;
            r_cnt        <= '0;
            for (int i = 0; i < NUM_HASH; i++) begin
                r_idx[i] <= '0;
            end
            r_ready_recv <= 1'b1;
            r_ready_res  <= 1'b0;
            r_result     <= 1'b0;
        end else begin
            r_ready_res <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_key        <= w_key;
                    r_hit        <= 1'b1;
                    r_cnt        <= '0;
                    r_ready_recv <= 1'b0;
                    r_state      <= S_HASH;
                end
                S_HASH: begin
                    for (int i = 0; i < NUM_HASH; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            r_idx[i] <= w_cur_hash;
                        end
                    end
                    r_hit <= w_hit_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_ready_res <= 1'b1;
                        r_result    <= w_hit_next;
                        r_state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    // Repeated indices simply set the same bit twice.
                    if ((LEARN != 0) && !r_hit) begin
                        for (int i = 0; i < NUM_HASH; i++) begin
                            r_array[r_idx[i]] <= 1'b1;
                        end
                    end
                    r_ready_recv <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_ready_recv <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign readyRecv  = r_ready_recv;
    assign readyRes   = r_ready_res;
    assign get_Result = r_result;

endmodule

// File: tb/tb_bloom_filter.sv
// Bench for bloom_filter: three variants (learning, lookup-only, all-ones init) run in lockstep
// against a cycle-phase reference model of the hash and membership array.
module tb_bloom_filter;

    localparam int ADDR_W   = 8;
    localparam int M        = 256;
    localparam int NUM_HASH = 3;
    localparam int KEY_W    = 104;
    localparam int NI       = 3;

    localparam logic [71:0] K1_IP  = 72'hC0A9011EC0A8011E1E;
    localparam logic [15:0] K1_SRC = 16'd16538;
    localparam logic [15:0] K1_DST = 16'd37281;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [71:0] ip_pro = '0;
    logic [15:0] src_port = '0;
    logic [15:0] dest_port = '0;
    logic        rr [NI];
    logic        rs [NI];
    logic        gr [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bloom_filter #(.ADDR_W(ADDR_W), .NUM_HASH(NUM_HASH), .LEARN(1), .INIT_VEC({256{1'b0}})) u_dut (
        .clk(clk), .reset(reset), .ip_pro(ip_pro), .src_port(src_port), .dest_port(dest_port),
        .readyRecv(rr[0]), .readyRes(rs[0]), .get_Result(gr[0]));

    bloom_filter #(.ADDR_W(ADDR_W), .NUM_HASH(NUM_HASH), .LEARN(0), .INIT_VEC({256{1'b0}})) u_nolearn (
        .clk(clk), .reset(reset), .ip_pro(ip_pro), .src_port(src_port), .dest_port(dest_port),
        .readyRecv(rr[1]), .readyRes(rs[1]), .get_Result(gr[1]));

    bloom_filter #(.ADDR_W(ADDR_W), .NUM_HASH(NUM_HASH), .LEARN(1), .INIT_VEC({256{1'b1}})) u_ones (
        .clk(clk), .reset(reset), .ip_pro(ip_pro), .src_port(src_port), .dest_port(dest_port),
        .readyRecv(rr[2]), .readyRes(rs[2]), .get_Result(gr[2]));

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] seeds [8] = '{8'h00, 8'h5A, 8'hC3, 8'h96, 8'h3C, 8'hA5, 8'h69, 8'hF0};
    int         m_learn [NI] = '{1, 0, 1};
    bit [M-1:0] m_arr [NI];
    bit         m_exp [NI];
    bit         m_res [NI];
    bit         m_known = 1'b0;
    int         m_phase = 0;
    logic [KEY_W-1:0] m_learned [$];

    function automatic logic [ADDR_W-1:0] ref_hash(input logic [KEY_W-1:0] k, input int i);
        logic [KEY_W-1:0]  r;
        logic [ADDR_W-1:0] h;
        logic [7:0]        sd;
        int                s;
        s = (11 * i) % KEY_W;
        for (int b = 0; b < KEY_W; b++) r[(b + s) % KEY_W] = k[b];
        h = '0;
        for (int b = 0; b < KEY_W; b++) h[b % ADDR_W] = h[b % ADDR_W] ^ r[b];
        sd = seeds[i];
        return h ^ sd;
    endfunction

    always @(posedge clk) begin
        logic [KEY_W-1:0]  key;
        logic [ADDR_W-1:0] h [NUM_HASH];
        bit                hit;
        if (!reset) begin
            m_phase = 0;
            for (int n = 0; n < NI; n++) begin
                m_arr[n] = (n == 2) ? {M{1'b1}} : {M{1'b0}};
                m_res[n] = 1'b0;
            end
            m_learned.delete();
            m_known = 1'b0;
        end else if (m_phase == 0) begin
            key = {ip_pro, src_port, dest_port};
            for (int i = 0; i < NUM_HASH; i++) h[i] = ref_hash(key, i);
            for (int n = 0; n < NI; n++) begin
                hit = 1'b1;
                for (int i = 0; i < NUM_HASH; i++) hit = hit & m_arr[n][h[i]];
                m_exp[n] = hit;
                if (m_learn[n] != 0 && !hit)
                    for (int i = 0; i < NUM_HASH; i++) m_arr[n][h[i]] = 1'b1;
            end
            m_known = 1'b0;
            foreach (m_learned[j]) if (m_learned[j] == key) m_known = 1'b1;
            if (!m_exp[0]) m_learned.push_back(key);
            m_phase = 1;
        end else begin
            m_phase++;
            if (m_phase == NUM_HASH + 2) m_phase = 0;
        end
        if (m_phase == NUM_HASH + 1)
            for (int n = 0; n < NI; n++) m_res[n] = m_exp[n];
        #1;
        for (int n = 0; n < NI; n++) begin
            chk($sformatf("readyRecv[%0d]", n), rr[n], m_phase == 0);
            chk($sformatf("readyRes[%0d]", n), rs[n], m_phase == NUM_HASH + 1);
            chk($sformatf("get_Result[%0d]", n), gr[n], m_res[n]);
        end
        if (m_phase == NUM_HASH + 1 && m_known) chk("no_false_neg", gr[0], 1'b1);
    end

    // ---------------- stimulus ----------------
    logic last_res [NI];
    logic last_rs  [NI];

    // Called at a negedge; returns at the negedge inside the RESULT cycle.
    task automatic lookup(input logic [71:0] ip, input logic [15:0] sp, input logic [15:0] dp);
        int guard = 0;
        while (m_phase != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_timeout", guard >= 20, 1'b0);
        ip_pro = ip; src_port = sp; dest_port = dp;
        repeat (NUM_HASH + 1) @(negedge clk);
        for (int n = 0; n < NI; n++) begin
            last_res[n] = gr[n];
            last_rs[n]  = rs[n];
        end
    endtask

    logic [71:0] pool_ip [$];
    logic [15:0] pool_sp [$];
    logic [15:0] pool_dp [$];

    initial begin
        logic [71:0] ip;
        logic [15:0] sp, dp;
        int          idx;

        reset = 1'b0;
        ip_pro = K1_IP; src_port = K1_SRC; dest_port = K1_DST;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        lookup(K1_IP, K1_SRC, K1_DST);
        chk("first_pulse", last_rs[0], 1'b1);
        chk("first_miss", last_res[0], 1'b0);
        chk("first_nolearn", last_res[1], 1'b0);
        chk("first_ones", last_res[2], 1'b1);
        $display("lookup K1 #1 -> %b %b %b", last_res[0], last_res[1], last_res[2]);

        lookup(K1_IP, K1_SRC, K1_DST);
        chk("learn_hit", last_res[0], 1'b1);
        chk("nolearn_stays0", last_res[1], 1'b0);
        chk("ones_hit", last_res[2], 1'b1);
        $display("lookup K1 #2 -> %b %b %b", last_res[0], last_res[1], last_res[2]);

        lookup(K1_IP, K1_SRC, 16'd37282);
        chk("flip_model", last_res[0], m_res[0]);
        $display("lookup K1 dp=37282 -> %b", last_res[0]);

        lookup(K1_IP, K1_SRC, K1_DST);
        chk("nolearn_repeat", last_res[1], 1'b0);
        chk("learned_again", last_res[0], 1'b1);
        $display("lookup K1 #3 -> %b %b %b", last_res[0], last_res[1], last_res[2]);

        // Abort a lookup of the learned key while it is hashing.
        @(negedge clk);
        while (m_phase != 0) @(negedge clk);
        ip_pro = K1_IP; src_port = K1_SRC; dest_port = K1_DST;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_readyRecv", rr[0], 1'b1);
        chk("midrst_readyRes", rs[0], 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_pulse", rs[0], 1'b0);
        end
        reset = 1'b1;
        lookup(K1_IP, K1_SRC, K1_DST);
        chk("requery_cleared", last_res[0], 1'b0);
        $display("lookup K1 after mid reset -> %b", last_res[0]);

        for (int t = 0; t < 1000; t++) begin
            if (pool_ip.size() > 0 && $urandom_range(3, 0) == 0) begin
                idx = $urandom_range(pool_ip.size() - 1, 0);
                ip = pool_ip[idx]; sp = pool_sp[idx]; dp = pool_dp[idx];
            end else begin
                ip = {$urandom(), $urandom(), 8'($urandom())};
                sp = 16'($urandom());
                dp = 16'($urandom());
                pool_ip.push_back(ip); pool_sp.push_back(sp); pool_dp.push_back(dp);
            end
            @(negedge clk);
            lookup(ip, sp, dp);
            chk("rand_model", last_res[0], m_res[0]);
            $display("rand %0d key=%h_%h_%h -> %b %b %b", t, ip, sp, dp,
                     last_res[0], last_res[1], last_res[2]);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
